// File: rtl/ddr_tx_ctrl.sv
// Burst sequencer feeding a DDR data lane and forwarded strobe lane with preamble/postamble framing.
// Optional training-pattern bursts are enabled by defining DDR_TX_CTRL_TRAIN_EN.
module ddr_tx_ctrl #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      BURST_W     = 8,
  parameter int unsigned      PRE_CYCLES  = 1,
  parameter int unsigned      POST_CYCLES = 1,
  parameter logic [WIDTH-1:0] IDLE_VAL    = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BURST_W-1:0]   burst_len,
  input  logic                 train,
  input  logic [2*WIDTH-1:0]   s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [WIDTH-1:0]     ddr_h,
  output logic [WIDTH-1:0]     ddr_l,
  output logic                 ddr_oe,
  output logic                 strb_h,
  output logic                 strb_l,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  localparam int unsigned PH_MAX = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] PRE_LAST  = PH_W'(PRE_CYCLES - 1);
  localparam logic [PH_W-1:0] POST_LAST = PH_W'(POST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_POST
  } state_t;

  state_t             state_q, state_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [WIDTH-1:0]   h_q, h_d;
  logic [WIDTH-1:0]   l_q, l_d;
  logic               sh_q, sh_d;
  logic               sl_q, sl_d;
  logic               oe_q, oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               und_q, und_d;

`ifdef DDR_TX_CTRL_TRAIN_EN
  localparam logic [WIDTH-1:0] PAT_A = WIDTH'({(WIDTH/2){2'b01}});
  localparam logic [WIDTH-1:0] PAT_B = WIDTH'({(WIDTH/2){2'b10}});

  logic train_q, train_d;
  logic pat_q, pat_d;

  assign s_ready = (state_q == S_DATA) && (cnt_q != '0) && !train_q;
`else
  logic unused_train;

  assign unused_train = train;
  assign s_ready      = (state_q == S_DATA) && (cnt_q != '0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    h_d     = IDLE_VAL;
    l_d     = IDLE_VAL;
    sh_d    = 1'b0;
    sl_d    = 1'b0;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    und_d   = und_q;
`ifdef DDR_TX_CTRL_TRAIN_EN
    train_d = train_q;
    pat_d   = pat_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            state_d = S_PRE;
            cnt_d   = burst_len;
            ph_d    = '0;
            und_d   = 1'b0;
            busy_d  = 1'b1;
            oe_d    = 1'b1;
`ifdef DDR_TX_CTRL_TRAIN_EN
            train_d = train;
            pat_d   = 1'b0;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_PRE: begin
        if (ph_q == PRE_LAST) begin
          state_d = S_DATA;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      S_DATA: begin
`ifdef DDR_TX_CTRL_TRAIN_EN
        if (train_q) begin
          if (cnt_q != '0) begin
            h_d   = pat_q ? PAT_B : PAT_A;
            l_d   = pat_q ? PAT_A : PAT_B;
            sh_d  = 1'b1;
            pat_d = ~pat_q;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == BURST_W'(1)) begin
              state_d = S_POST;
              ph_d    = '0;
            end
          end
        end else
`endif
        if (s_valid && s_ready) begin
          h_d   = s_data[2*WIDTH-1:WIDTH];
          l_d   = s_data[WIDTH-1:0];
          sh_d  = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == BURST_W'(1)) begin
            state_d = S_POST;
            ph_d    = '0;
          end
        end else begin
          // Stall: lane returns to idle and the strobe pauses until data resumes.
          und_d = 1'b1;
        end
      end

      S_POST: begin
        if (ph_q == POST_LAST) begin
          state_d = S_IDLE;
          ph_d    = '0;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      h_q     <= IDLE_VAL;
      l_q     <= IDLE_VAL;
      sh_q    <= 1'b0;
      sl_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
`ifdef DDR_TX_CTRL_TRAIN_EN
      train_q <= 1'b0;
      pat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      h_q     <= h_d;
      l_q     <= l_d;
      sh_q    <= sh_d;
      sl_q    <= sl_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      und_q   <= und_d;
`ifdef DDR_TX_CTRL_TRAIN_EN
      train_q <= train_d;
      pat_q   <= pat_d;
`endif
    end
  end

  assign ddr_h    = h_q;
  assign ddr_l    = l_q;
  assign strb_h   = sh_q;
  assign strb_l   = sl_q;
  assign ddr_oe   = oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = und_q;

endmodule

// File: tb/tb_ddr_tx_ctrl.sv
// Directed self-checking bench for ddr_tx_ctrl with default parameters (WIDTH=8, 1-cycle pre/postamble).
module tb_ddr_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  burst_len;
  logic        train;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  ddr_h;
  logic [7:0]  ddr_l;
  logic        ddr_oe;
  logic        strb_h;
  logic        strb_l;
  logic        busy;
  logic        done;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  ddr_tx_ctrl #(
    .WIDTH      (8),
    .BURST_W    (8),
    .PRE_CYCLES (1),
    .POST_CYCLES(1),
    .IDLE_VAL   (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .burst_len(burst_len),
    .train    (train),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .ddr_h    (ddr_h),
    .ddr_l    (ddr_l),
    .ddr_oe   (ddr_oe),
    .strb_h   (strb_h),
    .strb_l   (strb_l),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full lane view in one call: data halves, strobes, oe, busy, done.
  task automatic chk_lane(input string tag, input logic [7:0] eh, input logic [7:0] el,
                          input logic esh, input logic eoe, input logic ebusy, input logic edone);
    chk({tag, ".h"},    {24'h0, ddr_h}, {24'h0, eh});
    chk({tag, ".l"},    {24'h0, ddr_l}, {24'h0, el});
    chk({tag, ".sh"},   {31'h0, strb_h}, {31'h0, esh});
    chk({tag, ".sl"},   {31'h0, strb_l}, 32'h0);
    chk({tag, ".oe"},   {31'h0, ddr_oe}, {31'h0, eoe});
    chk({tag, ".busy"}, {31'h0, busy}, {31'h0, ebusy});
    chk({tag, ".done"}, {31'h0, done}, {31'h0, edone});
  endtask

  logic [15:0] words5 [5];

  initial begin
    words5[0] = 16'h1020;
    words5[1] = 16'h3040;
    words5[2] = 16'h5060;
    words5[3] = 16'h7080;
    words5[4] = 16'h90A0;

    rst_n = 1'b0; start = 1'b0; burst_len = '0; train = 1'b0; s_data = '0; s_valid = 1'b0;
    tick();
    tick();
    chk_lane("rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.ready", {31'h0, s_ready}, 32'h0);
    chk("rst.und", {31'h0, underrun}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle.oe", {31'h0, ddr_oe}, 32'h0);
      chk("idle.ready", {31'h0, s_ready}, 32'h0);
      chk("idle.busy", {31'h0, busy}, 32'h0);
    end

    // Basic 3-word burst, stream always valid.
    start = 1'b1; burst_len = 8'd3; s_valid = 1'b1; s_data = 16'hA1B2;
    tick();
    start = 1'b0;
    chk_lane("b3.pre", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("b3.pre.ready", {31'h0, s_ready}, 32'h0);
    tick();
    chk_lane("b3.d0", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("b3.d0.ready", {31'h0, s_ready}, 32'h1);
    tick();
    chk_lane("b3.w0", 8'hA1, 8'hB2, 1'b1, 1'b1, 1'b1, 1'b0);
    s_data = 16'hC3D4;
    tick();
    chk_lane("b3.w1", 8'hC3, 8'hD4, 1'b1, 1'b1, 1'b1, 1'b0);
    s_data = 16'hE5F6;
    tick();
    chk_lane("b3.w2", 8'hE5, 8'hF6, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("b3.post.ready", {31'h0, s_ready}, 32'h0);
    tick();
    chk_lane("b3.done", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b3.und", {31'h0, underrun}, 32'h0);

    // Start in the done cycle: 4-word burst with a 2-cycle stall after word 2.
    start = 1'b1; burst_len = 8'd4; s_valid = 1'b1; s_data = 16'h1122;
    tick();
    start = 1'b0;
    chk_lane("b4.pre", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("b4.d0.ready", {31'h0, s_ready}, 32'h1);
    tick();
    chk_lane("b4.w0", 8'h11, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
    s_data = 16'h3344;
    tick();
    chk_lane("b4.w1", 8'h33, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0);
    s_valid = 1'b0; s_data = 16'hDEAD;
    tick();
    chk_lane("b4.st0", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("b4.st0.und", {31'h0, underrun}, 32'h1);
    chk("b4.st0.ready", {31'h0, s_ready}, 32'h1);
    tick();
    chk_lane("b4.st1", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    s_valid = 1'b1; s_data = 16'h5566;
    tick();
    chk_lane("b4.w2", 8'h55, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0);
    s_data = 16'h7788;
    tick();
    chk_lane("b4.w3", 8'h77, 8'h88, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("b4.post.ready", {31'h0, s_ready}, 32'h0);
    tick();
    chk_lane("b4.done", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    chk("b4.und.hold", {31'h0, underrun}, 32'h1);
    chk("b4.done.once", {31'h0, done}, 32'h0);

    // Zero-length start: done next cycle, oe never rises.
    start = 1'b1; burst_len = 8'd0;
    tick();
    start = 1'b0;
    chk_lane("z.done", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_lane("z.after", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start during busy is ignored; burst stays 2 words.
    start = 1'b1; burst_len = 8'd2; s_valid = 1'b1; s_data = 16'hABCD;
    tick();
    chk("ib.und.clr", {31'h0, underrun}, 32'h0);
    burst_len = 8'd5;
    tick();
    start = 1'b0;
    chk("ib.d0.ready", {31'h0, s_ready}, 32'h1);
    tick();
    chk_lane("ib.w0", 8'hAB, 8'hCD, 1'b1, 1'b1, 1'b1, 1'b0);
    s_data = 16'hEF01;
    tick();
    chk_lane("ib.w1", 8'hEF, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("ib.post.ready", {31'h0, s_ready}, 32'h0);
    tick();
    chk_lane("ib.done", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Reset during DATA after the first of 5 words.
    start = 1'b1; burst_len = 8'd5; s_valid = 1'b1; s_data = words5[0];
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_lane("rm.w0", 8'h10, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
    s_data = words5[1];
    #2;
    rst_n = 1'b0;
    #1;
    chk_lane("rm.async", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rm.nodone", {31'h0, done}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk_lane("rm.rel", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    start = 1'b1; burst_len = 8'd5; s_valid = 1'b1; s_data = words5[0];
    tick();
    start = 1'b0;
    chk_lane("cb.pre", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("cb.d0.ready", {31'h0, s_ready}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 4) s_data = words5[i+1];
      chk("cb.h", {24'h0, ddr_h}, {24'h0, words5[i][15:8]});
      chk("cb.l", {24'h0, ddr_l}, {24'h0, words5[i][7:0]});
      chk("cb.sh", {31'h0, strb_h}, 32'h1);
      chk("cb.oe", {31'h0, ddr_oe}, 32'h1);
    end
    tick();
    chk_lane("cb.done", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cb.und", {31'h0, underrun}, 32'h0);
    s_valid = 1'b0;
    tick();

`ifdef DDR_TX_CTRL_TRAIN_EN
    // Training burst: stream ignored, alternating 55/AA pattern, no underrun.
    start = 1'b1; burst_len = 8'd4; train = 1'b1; s_valid = 1'b0;
    tick();
    start = 1'b0; train = 1'b0;
    chk_lane("tr.pre", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("tr.d0.ready", {31'h0, s_ready}, 32'h0);
    tick();
    chk_lane("tr.w0", 8'h55, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("tr.w0.ready", {31'h0, s_ready}, 32'h0);
    tick();
    chk_lane("tr.w1", 8'hAA, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_lane("tr.w2", 8'h55, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_lane("tr.w3", 8'hAA, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_lane("tr.done", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("tr.und", {31'h0, underrun}, 32'h0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
